// File: rtl/bg_pkg.sv
// bg_pkg: shared constants, colour type and procedural tile-sheet generator
package bg_pkg;

    typedef logic [11:0] rgb444_t;

    typedef enum logic [1:0] {
        SEL_BLANK,
        SEL_TRANSP,
        SEL_ROM
    } sel_t;

    localparam int TILE_SZ  = 32;
    localparam int WALL_COL = 0;
    localparam int WALL_ROW = 2;
    localparam int ROAD_COL = 7;
    localparam int ROAD_ROW = 1;

    localparam rgb444_t COLOR_TRANSPARENT = 12'h00F;
    localparam rgb444_t COLOR_BLANK       = 12'h000;
    localparam rgb444_t COLOR_MORTAR      = 12'hAAA;
    localparam rgb444_t COLOR_BRICK       = 12'hB42;
    localparam rgb444_t COLOR_ROAD        = 12'h444;
    localparam rgb444_t COLOR_ROAD_HI     = 12'h555;

    // Brick courses are 8 texels tall; vertical joints alternate between
    // column 15 and column 7 on successive courses to give a running bond.
    function automatic rgb444_t builtin_texel(int x, int y, int tsz);
        int lx, ly, tc, tr;
        lx = x % tsz;
        ly = y % tsz;
        tc = x / tsz;
        tr = y / tsz;
        if (tc == WALL_COL && tr == WALL_ROW)
            return (ly % 8 == 7 || lx % 16 == (((ly / 8) % 2 == 0) ? 15 : 7)) ? COLOR_MORTAR : COLOR_BRICK;
        if (tc == ROAD_COL && tr == ROAD_ROW)
            return (((lx / 8) ^ (ly / 8)) % 2 == 1) ? COLOR_ROAD_HI : COLOR_ROAD;
        return COLOR_TRANSPARENT;
    endfunction

endpackage

// File: rtl/bg_sync_rom.sv
// bg_sync_rom: single registered read port over a ROM filled at elaboration
module bg_sync_rom #(
  parameter int    DEPTH     = 24576,
  parameter int    WIDTH     = 12,
  parameter string INIT_FILE = "",
  parameter int    SHEET_W   = 256,
  parameter int    TILE_SZ   = 32
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [WIDTH-1:0]         q
);
  import bg_pkg::*;
  logic [WIDTH-1:0] mem [DEPTH];
  initial
    for (int i = 0; i < DEPTH; i++)
      mem[i] = WIDTH'(builtin_texel(i % SHEET_W, i / SHEET_W, TILE_SZ));
  always_ff @(posedge clk)
    q <= mem[addr];
endmodule

// File: rtl/bg_tile_rom.sv
// bg_tile_rom: tile-sheet texel lookup by (x, y) with blanking and range keying
module bg_tile_rom #(
    parameter int    SHEET_W   = 256,
    parameter int    SHEET_H   = 96,
    parameter int    TILE_SZ   = 32,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [11:0] color
);
    import bg_pkg::*;

    localparam int AW = $clog2(SHEET_W * SHEET_H);

    logic          in_range;
    logic [AW-1:0] addr;
    logic [11:0]   q;
    sel_t          sel;

    assign in_range = (x < 10'(SHEET_W)) && (y < 10'(SHEET_H));
    assign addr     = in_range ? AW'(y) * AW'(SHEET_W) + AW'(x) : '0;

    bg_sync_rom #(
        .DEPTH    (SHEET_W * SHEET_H),
        .WIDTH    (12),
        .INIT_FILE(INIT_FILE),
        .SHEET_W  (SHEET_W),
        .TILE_SZ  (TILE_SZ)
    ) u_rom (
        .clk (clk),
        .addr(addr),
        .q   (q)
    );

    // Track which source drives the output, aligned with the ROM read latency
    always_ff @(posedge clk) begin
        if (!rst_n)
            sel <= SEL_BLANK;
        else
            sel <= !video_on ? SEL_BLANK : !in_range ? SEL_TRANSP : SEL_ROM;
    end

    // Final output mux from the registered selector and ROM data
    always_comb
        color = sel == SEL_ROM ? q : sel == SEL_TRANSP ? COLOR_TRANSPARENT : COLOR_BLANK;

endmodule

// File: tb/tb_bg_tile_rom.sv
// tb_bg_tile_rom: directed and randomized checks against a behavioural sheet model
module tb_bg_tile_rom;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        video_on = 1'b1;
    logic [9:0]  x = 10'd5;
    logic [9:0]  y = 10'd70;
    logic [11:0] color;
    int          checks = 0;
    int          errors = 0;

    bg_tile_rom dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .video_on(video_on),
        .x       (x),
        .y       (y),
        .color   (color)
    );

    always #5 clk = ~clk;

    // Texel of the built-in sheet at in-range coordinates
    function automatic logic [11:0] ref_texel(int xi, int yi);
        logic [4:0] lx, ly;
        int tc, tr;
        lx = 5'(xi % 32);
        ly = 5'(yi % 32);
        tc = xi / 32;
        tr = yi / 32;
        if (tc == 0 && tr == 2)
            return (ly[2:0] == 3'd7 || lx[3:0] == {~ly[3], 3'b111}) ? 12'hAAA : 12'hB42;
        if (tc == 7 && tr == 1)
            return (lx[3] ^ ly[3]) ? 12'h555 : 12'h444;
        return 12'h00F;
    endfunction

    // Output expected one cycle after sampling these inputs
    function automatic logic [11:0] ref_color(logic r, logic v, int xi, int yi);
        if (!r) return 12'h000;
        if (!v) return 12'h000;
        if (xi >= 256 || yi >= 96) return 12'h00F;
        return ref_texel(xi, yi);
    endfunction

    task automatic check(string name, logic [11:0] got, logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h (x=%0d y=%0d v=%b t=%0t)", name, got, want, x, y, video_on, $time);
        end
    endtask

    // Every cycle: predict from the inputs sampled at this edge, compare just after it
    always @(posedge clk) begin
        logic [11:0] e;
        e = ref_color(rst_n, video_on, int'(x), int'(y));
        #1 check("model", color, e);
    end

    task automatic step(string name, int xi, int yi, logic v, logic [11:0] want);
        @(negedge clk);
        x = 10'(xi);
        y = 10'(yi);
        video_on = v;
        check({"ref_", name}, ref_color(1'b1, v, xi, yi), want);
        @(posedge clk);
        #1 check(name, color, want);
    endtask

    initial begin
        repeat (3) begin
            @(posedge clk);
            #1 check("reset", color, 12'h000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("first_texel", color, 12'hB42);

        step("wall_mortar_row", 0, 71, 1'b1, 12'hAAA);
        step("wall_brick", 3, 64, 1'b1, 12'hB42);
        step("wall_joint_even", 15, 64, 1'b1, 12'hAAA);
        step("wall_joint_odd", 7, 72, 1'b1, 12'hAAA);
        step("wall_brick_odd", 15, 72, 1'b1, 12'hB42);
        step("road_base", 224, 32, 1'b1, 12'h444);
        step("road_hi", 232, 32, 1'b1, 12'h555);
        step("road_both", 232, 40, 1'b1, 12'h444);
        step("empty_tile", 40, 10, 1'b1, 12'h00F);
        step("x_oor", 300, 10, 1'b1, 12'h00F);
        step("y_oor", 10, 200, 1'b1, 12'h00F);
        step("x_edge_alias", 256, 63, 1'b1, 12'h00F);
        step("y_edge_alias", 0, 96, 1'b1, 12'h00F);
        step("last_texel", 255, 95, 1'b1, 12'h00F);
        step("max_coords", 1023, 1023, 1'b1, 12'h00F);
        step("blank", 3, 64, 1'b0, 12'h000);
        step("blank_oor", 300, 10, 1'b0, 12'h000);
        step("unblank", 3, 64, 1'b1, 12'hB42);

        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            x = 10'(i);
            y = 10'd64;
            video_on = 1'b1;
        end

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            x = 10'($urandom_range(0, 300));
            y = 10'($urandom_range(0, 110));
            if ($urandom_range(0, 3) == 0) y = 10'($urandom_range(32, 95));
            video_on = $urandom_range(0, 9) != 0;
            rst_n = $urandom_range(0, 49) != 0;
        end

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
